// File: rtl/value_text_formatter.sv
// Formats a 14-bit signed-magnitude value into a 10-cell glyph buffer:
// sign, up to five digits with optional decimal point, and a unit suffix.
// The binary value is converted to BCD serially (one bit per cycle); the
// whole buffer is then rewritten in a single cycle.
module value_text_formatter #(
   parameter int unsigned N_CELLS = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [13:0] value,
   input  logic        neg,
   input  logic [1:0]  dp_pos,
   input  logic [1:0]  unit_sel,
   output logic        busy,
   output logic        done,
   input  logic [3:0]  rd_col,
   output logic [4:0]  rd_code
);

   localparam logic [4:0] GDot   = 5'd10;
   localparam logic [4:0] GMilli = 5'd11;
   localparam logic [4:0] GMicro = 5'd12;
   localparam logic [4:0] GVolt  = 5'd13;
   localparam logic [4:0] GBlank = 5'd16;
   localparam logic [4:0] GMinus = 5'd17;
   localparam logic [4:0] GSec   = 5'd21;

   typedef enum logic [1:0] {StIdle, StConvert, StFormat} state_e;

   state_e      state_q, state_d;
   logic [13:0] sh_q;
   logic [19:0] bcd_q;
   logic [19:0] bcd_adj;
   logic [3:0]  cnt_q;
   logic        neg_q;
   logic [1:0]  dp_q;
   logic [1:0]  unit_q;
   logic        done_q;
   logic [4:0]  cells_q [N_CELLS];
   logic [4:0]  cells_d [N_CELLS];

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: 14 shift iterations, then one format cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:    if (start) state_d = StConvert;
         StConvert: if (cnt_q == 4'd13) state_d = StFormat;
         StFormat:  state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q != StIdle);
      done = done_q;
   end

   // Add-3 correction applied to every BCD nibble ahead of each shift
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // Operand capture, serial BCD conversion and buffer update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_q   <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         neg_q  <= 1'b0;
         dp_q   <= '0;
         unit_q <= '0;
         done_q <= 1'b0;
         for (int c = 0; c < int'(N_CELLS); c++) cells_q[c] <= GBlank;
      end else begin
         done_q <= (state_q == StFormat);
         case (state_q)
            StIdle: begin
               if (start) begin
                  sh_q   <= value;
                  bcd_q  <= '0;
                  cnt_q  <= '0;
                  // A zero magnitude never shows a minus sign
                  neg_q  <= neg && (value != 14'd0);
                  dp_q   <= dp_pos;
                  unit_q <= unit_sel;
               end
            end
            StConvert: begin
               bcd_q <= {bcd_adj[18:0], sh_q[13]};
               sh_q  <= {sh_q[12:0], 1'b0};
               cnt_q <= cnt_q + 4'd1;
            end
            StFormat: begin
               for (int c = 0; c < int'(N_CELLS); c++) cells_q[c] <= cells_d[c];
            end
            default: ;
         endcase
      end
   end

   // Build the complete new buffer image from the finished BCD digits
   always_comb begin
      logic       lead;
      logic [3:0] dig;
      logic [3:0] pos;
      for (int c = 0; c < int'(N_CELLS); c++) cells_d[c] = GBlank;
      cells_d[0] = neg_q ? GMinus : GBlank;
      lead = 1'b1;
      dig  = '0;
      pos  = '0;
      for (int i = 4; i >= 0; i--) begin
         dig = bcd_q[4*i +: 4];
         // The digit at index dp_q (units, or left of '.') always shows
         if (dig != 4'd0 || i <= int'(dp_q)) lead = 1'b0;
         // Integer digits shift one cell left to make room for the point
         pos = (dp_q != 2'd0 && i >= int'(dp_q)) ? 4'(5 - i) : 4'(6 - i);
         cells_d[pos] = lead ? GBlank : {1'b0, dig};
      end
      if (dp_q != 2'd0) cells_d[4'd6 - {2'b00, dp_q}] = GDot;
      case (unit_q)
         2'd0: begin cells_d[7] = GVolt;  cells_d[8] = GBlank; end
         2'd1: begin cells_d[7] = GMilli; cells_d[8] = GVolt;  end
         2'd2: begin cells_d[7] = GMicro; cells_d[8] = GSec;   end
         default: begin cells_d[7] = GMilli; cells_d[8] = GSec; end
      endcase
   end

   assign rd_code = (rd_col < 4'(N_CELLS)) ? cells_q[rd_col] : GBlank;

endmodule

// File: tb/tb_value_text_formatter.sv
// Randomized self-checking bench for value_text_formatter with a printf-style
// reference model of the text buffer and a cycle-exact timing expectation.
module tb_value_text_formatter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [13:0] value;
   logic        neg;
   logic [1:0]  dp_pos;
   logic [1:0]  unit_sel;
   logic        busy;
   logic        done;
   logic [3:0]  rd_col;
   logic [4:0]  rd_code;

   int total = 0;
   int bad   = 0;
   int exp_buf [16];

   value_text_formatter #(.N_CELLS(10)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .value    (value),
      .neg      (neg),
      .dp_pos   (dp_pos),
      .unit_sel (unit_sel),
      .busy     (busy),
      .done     (done),
      .rd_col   (rd_col),
      .rd_code  (rd_code)
   );

   always #20 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void set_blank();
      for (int c = 0; c < 16; c++) exp_buf[c] = 16;
   endfunction

   // Expected buffer: sign, integer part right-aligned without leading zeros
   // (at least one digit), point, zero-padded fraction, unit suffix.
   function automatic void set_model(input int v, input int n, input int dp, input int u);
      int p10 = 1;
      int ip;
      int fp;
      int pos;
      set_blank();
      exp_buf[0] = (n != 0 && v != 0) ? 17 : 16;
      for (int i = 0; i < dp; i++) p10 = p10 * 10;
      ip  = v / p10;
      fp  = v % p10;
      pos = (dp == 0) ? 6 : 5 - dp;
      do begin
         exp_buf[pos] = ip % 10;
         ip = ip / 10;
         pos--;
      end while (ip > 0);
      if (dp > 0) begin
         exp_buf[6 - dp] = 10;
         for (int j = 0; j < dp; j++) begin
            exp_buf[6 - j] = fp % 10;
            fp = fp / 10;
         end
      end
      case (u)
         0: begin exp_buf[7] = 13; exp_buf[8] = 16; end
         1: begin exp_buf[7] = 11; exp_buf[8] = 13; end
         2: begin exp_buf[7] = 12; exp_buf[8] = 21; end
         default: begin exp_buf[7] = 11; exp_buf[8] = 21; end
      endcase
   endfunction

   task automatic sweep(input string tag);
      for (int c = 0; c < 16; c++) begin
         rd_col = 4'(c);
         #1;
         check($sformatf("%s[%0d]", tag, c), rd_code, exp_buf[c]);
      end
   endtask

   // Entered just after a negedge with the DUT idle (or in its done cycle).
   // Returns in the done cycle (k=16), or one cycle after an injected reset.
   task automatic do_conv(input int v, input int n, input int dp, input int u,
                          input bit pulse5, input int rst_at);
      value    = 14'(v);
      neg      = n[0];
      dp_pos   = 2'(dp);
      unit_sel = 2'(u);
      start    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      value    = 14'($urandom);
      neg      = 1'($urandom);
      dp_pos   = 2'($urandom);
      unit_sel = 2'($urandom);
      for (int k = 1; k <= 16; k++) begin
         if (rst_at != 0 && k > rst_at) begin
            check("busy_after_rst", busy, 0);
            check("done_after_rst", done, 0);
            set_blank();
            sweep("rst_buf");
            return;
         end
         check($sformatf("busy_c%0d", k), busy, (k <= 15) ? 1 : 0);
         check($sformatf("done_c%0d", k), done, (k == 16) ? 1 : 0);
         if (k <= 15) begin
            rd_col = 4'(k - 1);
            #1;
            check($sformatf("hold_c%0d", k - 1), rd_code, exp_buf[k - 1]);
         end
         if (pulse5 && k == 5) start = 1'b1;
         if (pulse5 && k == 6) start = 1'b0;
         if (k == rst_at) rst_n = 1'b0;
         if (k == 16) begin
            set_model(v, n, dp, u);
            sweep("buf");
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic after_done();
      @(negedge clk);
      check("done_once", done, 0);
      check("busy_idle", busy, 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      value    = '0;
      neg      = 1'b0;
      dp_pos   = '0;
      unit_sel = '0;
      rd_col   = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      set_blank();
      sweep("rst_cell");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases with known buffer images
      do_conv(1234, 0, 3, 0, 1'b0, 0);
      after_done();
      do_conv(0, 1, 0, 1, 1'b0, 0);
      after_done();
      do_conv(16383, 1, 0, 3, 1'b0, 0);
      after_done();
      do_conv(5, 0, 3, 2, 1'b0, 0);
      after_done();

      // Start while busy is ignored; start in the done cycle is accepted
      do_conv(777, 0, 1, 1, 1'b1, 0);
      after_done();
      do_conv(42, 1, 2, 0, 1'b0, 0);
      do_conv(9999, 0, 0, 2, 1'b0, 0);
      after_done();

      // Reset mid-conversion: no done, blank buffer, start ignored under reset
      do_conv(321, 0, 0, 0, 1'b0, 8);
      start = 1'b1;
      value = 14'd100;
      @(negedge clk);
      check("busy_in_rst", busy, 0);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("busy_post_rst", busy, 0);
         check("done_post_rst", done, 0);
      end

      // Randomized conversions, biased toward boundary magnitudes
      for (int t = 0; t < 40; t++) begin
         int v;
         case ($urandom_range(0, 5))
            0: v = 0;
            1: v = 16383;
            2: v = $urandom_range(0, 9);
            default: v = $urandom_range(0, 16383);
         endcase
         do_conv(v, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'($urandom), 0);
         if ($urandom_range(0, 3) != 0) after_done();
      end
      after_done();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
